// File: rtl/imem_port_arbiter.sv
// Two-requester arbiter for the single instruction-memory port: fetch (F) vs loader (L).
// Round-robin with a burst cap on L, a fixed-latency response pipe, and flush-kill of F reads.
module imem_port_arbiter #(
    parameter int MEM_LAT   = 1,
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);
    localparam logic       OWN_F = 1'b0;
    localparam logic       OWN_L = 1'b1;
    localparam logic [3:0] BMAX  = 4'(BURST_MAX);

    logic               rr_ptr;
    logic [3:0]         burst_cnt;
    logic [MEM_LAT-1:0] pipe_vld;
    logic [MEM_LAT-1:0] pipe_own;
    logic [MEM_LAT:0]   vld_ext;
    logic [MEM_LAT:0]   own_ext;
    logic               f_act;
    logic               l_act;
    logic               contend;
    logic               pick_f;
    logic               head_vld;
    logic               head_own;

    // Grants are held low during reset even though requests may already be up.
    always_comb begin
        f_act   = f_req & ~flush & rst_n;
        l_act   = l_req & rst_n;
        contend = f_act & l_act;
        pick_f  = (burst_cnt >= BMAX) || (rr_ptr == OWN_F);
        f_gnt   = f_act & (~l_act | pick_f);
        l_gnt   = l_act & (~f_act | ~pick_f);
    end

    always_comb begin
        m_req   = f_gnt | l_gnt;
        m_we    = l_gnt & l_we;
        m_wdata = l_gnt ? l_wdata : 32'h0;
        m_addr  = 32'h0;
        if (f_gnt)
            m_addr = f_addr;
        else if (l_gnt)
            m_addr = l_addr;
    end

    // Push at bit 0; the top bit of the extended vector is the entry leaving the head.
    always_comb begin
        vld_ext = {pipe_vld, f_gnt | (l_gnt & ~l_we)};
        own_ext = {pipe_own, l_gnt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= OWN_F;
            burst_cnt <= 4'd0;
            pipe_vld  <= '0;
            pipe_own  <= '0;
        end else begin
            if (contend)
                rr_ptr <= f_gnt ? OWN_L : OWN_F;
            if (l_gnt && f_req)
                burst_cnt <= (burst_cnt >= BMAX) ? BMAX : burst_cnt + 4'd1;
            else
                burst_cnt <= 4'd0;
            // A flush drops every F-owned read still travelling toward the head.
            pipe_vld <= vld_ext[MEM_LAT-1:0] & (flush ? own_ext[MEM_LAT-1:0] : '1);
            pipe_own <= own_ext[MEM_LAT-1:0];
        end
    end

    always_comb begin
        head_vld = pipe_vld[MEM_LAT-1];
        head_own = pipe_own[MEM_LAT-1];
        f_rvalid = head_vld & (head_own == OWN_F) & ~flush;
        l_rvalid = head_vld & (head_own == OWN_L);
        f_rdata  = f_rvalid ? m_rdata : 32'h0;
        l_rdata  = l_rvalid ? m_rdata : 32'h0;
    end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus random traffic, scored every cycle
// against a transaction-level model (grant decision, response queue by due cycle, word memory).
module tb_imem_port_arbiter;
    localparam int MEM_LAT   = 2;
    localparam int BURST_MAX = 3;

    logic        clk = 1'b0;
    logic        rst_n, flush, f_req, l_req, l_we;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_gnt, f_rvalid, l_gnt, l_rvalid, m_req, m_we;
    logic [31:0] f_rdata, l_rdata, m_addr, m_wdata, m_rdata;

    always #5 clk = ~clk;

    imem_port_arbiter #(.MEM_LAT(MEM_LAT), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
        .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Environment memory: write-first, read data appears MEM_LAT cycles after the access.
    logic [31:0] emem [256];
    logic [31:0] rd_q [MEM_LAT];
    always @(posedge clk) begin
        if (m_req && m_we) emem[m_addr[9:2]] <= m_wdata;
        for (int i = MEM_LAT - 1; i > 0; i--) rd_q[i] <= rd_q[i-1];
        rd_q[0] <= emem[m_addr[9:2]];
    end
    assign m_rdata = rd_q[MEM_LAT-1];

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model state
    typedef struct { int due; bit own; logic [31:0] data; } resp_t;
    resp_t       q[$];
    logic [31:0] mmem [256];
    bit          prefer_l;     // 1 when the last contended grant went to F
    int          l_run;        // consecutive L grants seen while F was requesting
    bit          ef, el, evf, evl;
    logic [31:0] ed, ea;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_f_gnt", f_gnt, 0);
            chk("rst_l_gnt", l_gnt, 0);
            chk("rst_m_req", m_req, 0);
            chk("rst_m_we", m_we, 0);
            chk("rst_f_rvalid", f_rvalid, 0);
            chk("rst_l_rvalid", l_rvalid, 0);
            q.delete();
            prefer_l = 0;
            l_run = 0;
        end else begin
            if (f_req && !flush && l_req) begin
                ef = (l_run >= BURST_MAX) || !prefer_l;
                el = !ef;
                prefer_l = ef;
            end else begin
                ef = f_req && !flush;
                el = l_req && !ef;
            end
            ea = ef ? f_addr : (el ? l_addr : 32'h0);
            chk("f_gnt", f_gnt, ef);
            chk("l_gnt", l_gnt, el);
            chk("m_req", m_req, ef | el);
            chk("m_we", m_we, el & l_we);
            chk("m_addr", m_addr, ea);
            chk("m_wdata", m_wdata, el ? l_wdata : 32'h0);

            evf = 0; evl = 0; ed = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                if (q[0].own) evl = 1;
                else evf = !flush;
                ed = q[0].data;
                void'(q.pop_front());
            end
            chk("f_rvalid", f_rvalid, evf);
            chk("f_rdata", f_rdata, evf ? ed : 32'h0);
            chk("l_rvalid", l_rvalid, evl);
            chk("l_rdata", l_rdata, evl ? ed : 32'h0);

            if (flush)
                for (int i = q.size() - 1; i >= 0; i--) if (!q[i].own) q.delete(i);
            l_run = (el && f_req) ? l_run + 1 : 0;
            if (ef) q.push_back('{cyc + MEM_LAT, 1'b0, mmem[f_addr[9:2]]});
            if (el && !l_we) q.push_back('{cyc + MEM_LAT, 1'b1, mmem[l_addr[9:2]]});
            if (el && l_we) mmem[l_addr[9:2]] = l_wdata;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic fg, lg;

    initial begin
        for (int i = 0; i < 256; i++) begin
            emem[i] = 32'hA000_0000 + i;
            mmem[i] = 32'hA000_0000 + i;
        end
        for (int i = 0; i < MEM_LAT; i++) rd_q[i] = 32'h0;
        rst_n = 0; flush = 0; f_req = 1; f_addr = 0;
        l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;

        // Reset hold, then release with F already requesting
        repeat (3) @(negedge clk);
        #1;
        chk("hold_f_gnt", f_gnt, 0);
        chk("hold_m_req", m_req, 0);
        step();
        rst_n = 1;
        #1 chk("release_f_gnt", f_gnt, 1);
        step();
        f_req = 0;
        repeat (MEM_LAT - 1) step();
        chk("first_f_rvalid", f_rvalid, 1);
        chk("first_f_rdata", f_rdata, 32'hA000_0000);

        // Streaming fetch
        step();
        for (int i = 0; i < 4; i++) begin
            f_req = 1; f_addr = 32'(i * 4);
            #1 chk("stream_f_gnt", f_gnt, 1);
            step();
        end
        f_req = 0;
        repeat (MEM_LAT + 1) step();

        // Burst cap: F wins a contended cycle, then flush cycles let L run to the cap
        f_req = 1; f_addr = 32'h200;
        l_req = 1; l_we = 1; l_addr = 32'h100; l_wdata = 32'hD000_0100;
        #1 chk("burst_first_f", f_gnt, 1);
        step();
        f_addr = 32'h204; flush = 1;
        for (int k = 0; k < BURST_MAX; k++) begin
            l_addr = 32'h100 + 32'(4 * k); l_wdata = 32'hD000_0000 | l_addr;
            #1 chk("burst_l_gnt", l_gnt, 1);
            step();
        end
        flush = 0;
        l_addr = 32'h100 + 32'(4 * BURST_MAX); l_wdata = 32'hD000_0000 | l_addr;
        #1 chk("burst_force_f_gnt", f_gnt, 1);
        chk("burst_force_l_gnt", l_gnt, 0);
        step();
        f_req = 0;
        #1 chk("burst_resume_l_gnt", l_gnt, 1);
        step();
        l_req = 0; l_we = 0;
        f_req = 1; f_addr = 32'h104;
        step();
        f_req = 0;
        repeat (MEM_LAT - 1) step();
        chk("raw_f_rvalid", f_rvalid, 1);
        chk("raw_f_rdata", f_rdata, 32'hD000_0104);
        repeat (2) step();

        // Flush the cycle after an F grant; an L read in the flush cycle survives
        f_req = 1; f_addr = 32'h20;
        step();
        flush = 1; f_addr = 32'h24;
        l_req = 1; l_we = 0; l_addr = 32'h40;
        #1 chk("flush_f_gnt", f_gnt, 0);
        chk("flush_l_gnt", l_gnt, 1);
        step();
        flush = 0; l_req = 0;
        chk("flush_killed_rvalid", f_rvalid, 0);
        step();
        f_req = 0;
        chk("flush_l_rvalid", l_rvalid, 1);
        chk("flush_l_rdata", l_rdata, 32'hA000_0010);
        repeat (3) step();

        // Reset while a fetch response is at the head
        f_req = 1; f_addr = 32'h8;
        step();
        f_req = 0;
        repeat (MEM_LAT - 1) step();
        chk("pre_reset_f_rvalid", f_rvalid, 1);
        f_req = 1;
        #1 rst_n = 0;
        #1 chk("async_f_rvalid", f_rvalid, 0);
        chk("async_f_gnt", f_gnt, 0);
        step();
        step();
        f_req = 0; rst_n = 1;
        repeat (MEM_LAT + 2) step();

        // Random traffic; requesters hold until granted
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            fg = f_gnt; lg = l_gnt;
            step();
            if (c == 300) rst_n = 0;
            if (c == 303) rst_n = 1;
            if (!f_req || fg) begin
                f_req  = $urandom_range(0, 3) != 0;
                f_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!l_req || lg) begin
                l_req   = $urandom_range(0, 1) != 0;
                l_we    = $urandom_range(0, 1) != 0;
                l_addr  = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
                l_wdata = $urandom;
            end
            flush = $urandom_range(0, 7) == 0;
        end
        f_req = 0; l_req = 0; flush = 0;
        repeat (MEM_LAT + 2) step();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single instruction-memory port between two requesters: the fetch stage (requester F) and the program loader/debug port (requester L).
- Arbitrates the two requesters, muxes address and write data onto the memory port, and routes read data back to the owner after a fixed latency.
- Discards fetch responses that are in flight when a branch redirect (flush) occurs.
- Sits between instruction fetch and the instruction memory.

Parameters:
- MEM_LAT, 1, memory read latency in cycles (legal range 1..4).
- BURST_MAX, 4, maximum consecutive L grants while F is requesting (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  branch redirect; kills in-flight fetch reads.
- f_req  input  1  fetch read request.
- f_addr  input  32  fetch byte address.
- f_gnt  output  1  fetch request accepted this cycle.
- f_rvalid  output  1  fetch read data valid.
- f_rdata  output  32  fetch read data.
- l_req  input  1  loader request.
- l_we  input  1  loader write (1) or read (0).
- l_addr  input  32  loader byte address.
- l_wdata  input  32  loader write data.
- l_gnt  output  1  loader request accepted this cycle.
- l_rvalid  output  1  loader read data valid.
- l_rdata  output  32  loader read data.
- m_req  output  1  memory access strobe.
- m_we  output  1  memory write enable.
- m_addr  output  32  memory byte address.
- m_wdata  output  32  memory write data.
- m_rdata  input  32  memory read data, valid MEM_LAT cycles after the m_req read.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All grants, m_req, m_we and rvalids are 0.
  - The response pipe is cleared, the round-robin pointer goes to F, and burst_cnt goes to 0.
  - Grants stay 0 while rst_n is low.
  - Any access in flight when reset asserts is dropped and produces no rvalid after reset releases.
- Grants:
  - Grants are combinational from the current requests and registered state.
  - At most one grant per cycle.
  - A requester holds its request and address until it sees its grant.
- Memory port:
  - m_req = f_gnt | l_gnt.
  - m_addr, m_we and m_wdata come from the granted requester.
  - m_we and m_wdata are 0 when F is granted.
  - When there is no grant, m_addr and m_wdata are 0.
- Arbitration:
  - Only one requester active: that requester is granted.
  - Both active: the requester pointed to by rr_ptr is granted. After any contended grant, rr_ptr points to the other requester.
  - Burst rule:
    - While L is granted in consecutive cycles and f_req is high, burst_cnt increments.
    - When burst_cnt reaches BURST_MAX, F is granted next regardless of rr_ptr.
    - burst_cnt clears on any F grant, on any cycle without an L grant, and in any cycle where f_req is low.
- Flush:
  - flush=1 forces f_gnt=0 in that cycle; L may still be granted.
  - All F-owned read entries in the response pipe are invalidated at that clock edge.
  - An F entry whose data would emerge in the flush cycle itself is also suppressed (f_rvalid=0).
- Response pipe:
  - MEM_LAT-deep shift register of {valid, owner}.
  - A read grant pushes {1, owner}; a write grant or no grant pushes {0, -}.
  - Writes generate no rvalid.
  - At the pipe head, x_rvalid=1 for the owner and x_rdata=m_rdata.
  - The non-owner's rdata is 0, and rdata is 0 whenever rvalid is 0.
- Throughput and latency:
  - One access per cycle, back-to-back, with no bubbles.
  - Read latency from grant to rvalid is exactly MEM_LAT cycles.
  - Responses return in grant order.
- Same-address ordering:
  - An L write followed by an F read of the same address in the next cycle returns the new data. The memory is write-first per access order, so no hazard logic is required here.

Test Plan:
- Reset and idle: hold rst_n=0 with f_req=1 -> f_gnt=0, m_req=0. Release rst_n -> f_gnt=1 the same cycle; f_rvalid rises MEM_LAT=1 cycle later with f_rdata equal to the memory word at f_addr=0x0.
- Streaming fetch: F alone, addresses 0x0, 0x4, 0x8, 0xC on consecutive cycles -> four grants in a row, then four consecutive f_rvalid pulses in order, with data mem[0..3].
- Contention: f_req=l_req=1 continuously, L reads, BURST_MAX=4, rr_ptr=F after reset -> grant pattern F, L, F, L, ...; each response is routed only to its owner, and the other rdata stays 0.
- Burst limit: L holds a write burst to 0x100..0x11C with f_req=1 and rr_ptr forced toward L -> at most 4 consecutive l_gnt, then f_gnt=1. Writes produce no l_rvalid. A subsequent F read of 0x104 returns l_wdata.
- Flush: F reads 0x20 with MEM_LAT=2 and flush=1 the cycle after the grant -> no f_rvalid for 0x20, f_gnt=0 in the flush cycle, and an L read issued in the flush cycle still returns l_rvalid 2 cycles later.
- Reset mid-operation: pull rst_n low while an F read is in flight -> outputs clear immediately, and no f_rvalid appears after release until a new grant.
